// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched
// Brief    : Round-robin scheduler sharing one non-pipelined, variable-latency
//            multiplier among N_REQ requesters. Define MULT_SCHED_TIMEOUT_EN
//            to add a WAIT-state timeout reported on rsp_err.
// Revision : 1.0
// ============================================================================
module mult_share_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int MIN_LAT    = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    output logic [2*DATA_WIDTH-1:0]     rsp_z,
    output logic                        rsp_err,
    output logic [DATA_WIDTH-1:0]       m_a,
    output logic [DATA_WIDTH-1:0]       m_b,
    output logic                        m_valid,
    input  logic                        m_ovalid,
    input  logic [2*DATA_WIDTH-1:0]     m_c,
    output logic                        busy
);

    localparam int              ID_W      = $clog2(N_REQ);
    localparam int              BL_W      = (MIN_LAT < 1) ? 1 : $clog2(MIN_LAT + 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [BL_W-1:0] BLANK_END = BL_W'(MIN_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]   m_a_q, m_a_d, m_b_q, m_b_d;
    logic [2*DATA_WIDTH-1:0] rsp_z_q, rsp_z_d;
    logic [BL_W-1:0]         blank_q, blank_d;
    logic                    blank_done;

    logic                    found;
    logic [ID_W-1:0]         grant;
    logic [ID_W-1:0]         cand;
    int                      idx;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b;

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam logic [7:0]   TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]              tmo_q, tmo_d;
    logic                    rsp_err_q, rsp_err_d;
`else
    logic                    unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Round-robin search starting at rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant == ID_W'(k)) begin
                sel_a = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                sel_b = req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign blank_done = (blank_q >= BLANK_END);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rsp_id_d = rsp_id_q;
        m_a_d    = m_a_q;
        m_b_d    = m_b_q;
        rsp_z_d  = rsp_z_q;
        blank_d  = blank_q;
`ifdef MULT_SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    m_a_d    = sel_a;
                    m_b_d    = sel_b;
                    rsp_id_d = grant;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                blank_d = '0;
`ifdef MULT_SCHED_TIMEOUT_EN
                tmo_d     = '0;
                rsp_err_d = 1'b0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The multiplier's o_valid may still reflect the previous
                // operation until MIN_LAT cycles have elapsed.
                if (!blank_done) begin
                    blank_d = blank_q + BL_W'(1);
                end
                if (blank_done && m_ovalid) begin
                    rsp_z_d = m_c;
                    state_d = S_RESP;
                end
`ifdef MULT_SCHED_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rsp_z_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (rsp_id_q == LAST_ID) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = rsp_id_q + ID_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            rsp_id_q  <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            rsp_z_q   <= '0;
            blank_q   <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= rsp_id_d;
            m_a_q     <= m_a_d;
            m_b_q     <= m_b_d;
            rsp_z_q   <= rsp_z_d;
            blank_q   <= blank_d;
`ifdef MULT_SCHED_TIMEOUT_EN
            tmo_q     <= tmo_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

`ifdef MULT_SCHED_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign m_valid   = (state_q == S_ISSUE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign m_a       = m_a_q;
    assign m_b       = m_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_sched
// Brief    : Self-checking bench for mult_share_sched with a behavioural
//            variable-latency multiplier and a round-robin reference model.
// Revision : 1.0
// ============================================================================
module tb_mult_share_sched;

    localparam int DW      = 32;
    localparam int N       = 4;
    localparam int MIN_LAT = 2;
    localparam int TMO     = 8;
    localparam int IW      = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a = '0;
    logic [N*DW-1:0]   req_b = '0;
    logic              rsp_valid, rsp_err, m_valid, m_ovalid, busy;
    logic              rsp_ready = 1'b0;
    logic [IW-1:0]     rsp_id;
    logic [2*DW-1:0]   rsp_z, m_c;
    logic [DW-1:0]     m_a, m_b;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Multiplier model: mode 0 = o_valid rises mm_lat cycles after the issue
    // edge and stays high (stale) until the next i_valid; 1 = o_valid stuck
    // high with a cycle-stamped o_c; 2 = o_valid stuck low.
    int          mm_mode = 0;
    int          mm_lat  = 2;
    int          mm_cnt  = 0;
    logic        mm_ov   = 1'b0;
    logic [63:0] mm_c    = '0;
    logic [63:0] mm_pend = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid) begin
            mm_cnt = mm_lat;
            mm_ov   <= 1'b0;
            mm_pend <= 64'(m_a) * 64'(m_b);
        end else if (mm_cnt > 0) begin
            mm_cnt = mm_cnt - 1;
            if (mm_cnt == 0) begin
                mm_ov <= 1'b1;
                mm_c  <= mm_pend;
            end
        end
    end

    assign m_ovalid = (mm_mode == 1) ? 1'b1 : (mm_mode == 2) ? 1'b0 : mm_ov;
    assign m_c      = (mm_mode == 1) ? {32'hC0DE0000, 32'(cyc)} : mm_c;

    mult_share_sched #(
        .DATA_WIDTH(DW), .N_REQ(N), .MIN_LAT(MIN_LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .m_a(m_a), .m_b(m_b), .m_valid(m_valid),
        .m_ovalid(m_ovalid), .m_c(m_c), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] z;
    } vec_t;

    vec_t tbl[6];

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_grant(output int g);
        int k;
        k = 0;
        g = -1;
        while (g < 0 && k < 200) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
            if (g < 0) @(negedge clk);
            k++;
        end
        if (g < 0) begin
            vecs++; errs++;
            $display("FAIL grant_timeout: req_ready=0 required a grant within 200 cycles");
        end
    endtask

    task automatic wait_rsp(input logic [N-1:0] drop, output int pulses);
        int  k;
        bit  ok;
        k = 0; ok = 1'b0; pulses = 0;
        while (!ok && k < 200) begin
            @(negedge clk);
            if (k == 0) req_valid = req_valid & ~drop;
            #1;
            if (m_valid) pulses++;
            ok = rsp_valid;
            k++;
        end
        if (!ok) begin
            vecs++; errs++;
            $display("FAIL rsp_timeout: rsp_valid=0 required 1 within 200 cycles");
        end
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g, t0, pulses, ptr, t_acc, g_cur, lat_cur, n_done, k;
        bit          infl;
        logic [N-1:0] pend, exp_mask;
        logic [31:0] ra[N], rb[N];
        logic [31:0] cur_a, cur_b;

        tbl = '{
            '{0, 32'd342,        32'd25,         2, 64'd8550},
            '{1, 32'd0,          32'hFFFFFFFF,   1, 64'd0},
            '{2, 32'hFFFFFFFF,   32'hFFFFFFFF,   4, 64'hFFFFFFFE00000001},
            '{3, 32'd12345,      32'd6789,       6, 64'd83810205},
            '{0, 32'd1,          32'd1,          2, 64'd1},
            '{3, 32'h80000000,   32'd2,          3, 64'h100000000}
        };

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_err, m_valid, busy}), 64'd0);
        chk("reset_rsp_z", rsp_z, 64'd0);
        chk("reset_m_ab", {m_a, m_b}, 64'd0);
        rst = 1'b0;

        // Single-requester table: product, id, latency, one issue pulse
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mm_lat = tbl[i].lat;
            req_a[tbl[i].id*DW +: DW] = tbl[i].a;
            req_b[tbl[i].id*DW +: DW] = tbl[i].b;
            req_valid = '0;
            req_valid[tbl[i].id] = 1'b1;
            wait_grant(g);
            t0 = cyc;
            chk("tbl_grant", 64'(g), 64'(tbl[i].id));
            wait_rsp(req_valid, pulses);
            chk("tbl_rsp_z", rsp_z, tbl[i].z);
            chk("tbl_rsp_id", 64'(rsp_id), 64'(tbl[i].id));
            chk("tbl_rsp_err", 64'(rsp_err), 64'd0);
            chk("tbl_latency", 64'(cyc - t0), 64'(3 + mx(MIN_LAT, tbl[i].lat)));
            chk("tbl_m_valid_pulses", 64'(pulses), 64'd1);
            take();
        end

        // All four requesters held: grant order 0,1,2,3,0
        do_reset();
        @(negedge clk);
        mm_lat = 1;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = 32'(i + 1);
            req_b[i*DW +: DW] = 32'd3;
        end
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            chk("rr_order", 64'(g), 64'(n % N));
            wait_rsp('0, pulses);
            chk("rr_rsp_z", rsp_z, 64'(3 * ((n % N) + 1)));
            chk("rr_rsp_id", 64'(rsp_id), 64'(n % N));
            take();
        end
        req_valid = '0;

        // Blanking: o_valid held high, capture must happen at T+4
        @(negedge clk);
        mm_mode = 1;
        req_a[1*DW +: DW] = 32'd5;
        req_b[1*DW +: DW] = 32'd7;
        req_valid[1] = 1'b1;
        wait_grant(g);
        t0 = cyc;
        wait_rsp(4'b0010, pulses);
        chk("blank_latency", 64'(cyc - t0), 64'd5);
        chk("blank_capture", rsp_z, {32'hC0DE0000, 32'(t0 + 4)});
        take();
        mm_mode = 0;

        // Response back-pressure for 10 cycles with another request pending
        @(negedge clk);
        mm_lat = 2;
        req_a[2*DW +: DW] = 32'd1000;
        req_b[2*DW +: DW] = 32'd77;
        req_valid = 4'b0100;
        wait_grant(g);
        chk("bp_grant", 64'(g), 64'd2);
        @(negedge clk);
        req_valid = 4'b0001;
        req_a[0 +: DW] = 32'd9;
        req_b[0 +: DW] = 32'd11;
        wait_rsp('0, pulses);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("bp_hold_ctl", 64'({rsp_valid, busy, req_ready, m_valid, rsp_id}),
                64'({1'b1, 1'b1, 4'b0000, 1'b0, 2'd2}));
            chk("bp_hold_z", rsp_z, 64'd77000);
        end
        take();
        wait_grant(g);
        chk("bp_next_grant", 64'(g), 64'd0);
        wait_rsp(4'b0001, pulses);
        chk("bp_next_z", rsp_z, 64'd99);
        take();

        // Reset in WAIT: async clear, then a clean operation
        @(negedge clk);
        mm_lat = 3;
        req_a[3*DW +: DW] = 32'd1000;
        req_b[3*DW +: DW] = 32'd1000;
        req_valid = 4'b1000;
        wait_grant(g);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_err, m_valid, busy}), 64'd0);
        chk("rst_mid_z", rsp_z, 64'd0);
        chk("rst_mid_m_ab", {m_a, m_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mm_lat = 1;
        req_a[0 +: DW] = 32'd0;
        req_b[0 +: DW] = 32'd1;
        req_valid = 4'b0001;
        wait_grant(g);
        chk("rst_after_grant", 64'(g), 64'd0);
        wait_rsp(4'b0001, pulses);
        chk("rst_after_z", rsp_z, 64'd0);
        chk("rst_after_pulses", 64'(pulses), 64'd1);
        take();

`ifdef MULT_SCHED_TIMEOUT_EN
        // o_valid stuck low: timeout after TMO WAIT cycles
        @(negedge clk);
        mm_mode = 2;
        req_a[1*DW +: DW] = 32'd3;
        req_b[1*DW +: DW] = 32'd4;
        req_valid = 4'b0010;
        wait_grant(g);
        t0 = cyc;
        wait_rsp(4'b0010, pulses);
        chk("tmo_latency", 64'(cyc - t0), 64'(TMO + 2));
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_z", rsp_z, 64'd0);
        take();
        mm_mode = 0;
`endif

        // Randomized traffic against a round-robin reference model
        do_reset();
        pend = '0; ptr = 0; infl = 1'b0; t_acc = 0; g_cur = 0; lat_cur = 1;
        n_done = 0; k = 0; cur_a = '0; cur_b = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
        while (n_done < 40 && k < 5000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = $urandom;
                    rb[i] = $urandom;
                    req_a[i*DW +: DW] = ra[i];
                    req_b[i*DW +: DW] = rb[i];
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (!infl) mm_lat = $urandom_range(1, 6);
            #1;
            if (!infl) begin
                exp_mask = '0;
                for (int j = 0; j < N; j++) begin
                    if (pend[(ptr + j) % N]) begin
                        exp_mask[(ptr + j) % N] = 1'b1;
                        break;
                    end
                end
                chk("rnd_grant", 64'(req_ready), 64'(exp_mask));
                chk("rnd_idle_out", 64'({busy, m_valid, rsp_valid}), 64'd0);
                if (pend != '0) begin
                    for (int j = 0; j < N; j++) if (exp_mask[j]) g_cur = j;
                    infl    = 1'b1;
                    t_acc   = cyc;
                    lat_cur = mm_lat;
                    cur_a   = ra[g_cur];
                    cur_b   = rb[g_cur];
                    pend[g_cur] = 1'b0;
                end
            end else begin
                chk("rnd_busy_ready", 64'({busy, req_ready}), 64'({1'b1, 4'b0000}));
                chk("rnd_m_valid", 64'(m_valid), 64'(cyc == t_acc + 1));
                chk("rnd_rsp_valid", 64'(rsp_valid),
                    64'(cyc >= t_acc + 3 + mx(MIN_LAT, lat_cur)));
                if (rsp_valid) begin
                    chk("rnd_rsp_id", 64'(rsp_id), 64'(g_cur));
                    chk("rnd_rsp_z", rsp_z, 64'(cur_a) * 64'(cur_b));
                    chk("rnd_rsp_err", 64'(rsp_err), 64'd0);
                    if (rsp_ready) begin
                        infl = 1'b0;
                        ptr  = (g_cur + 1) % N;
                        n_done++;
                    end
                end
            end
            k++;
        end
        if (n_done < 40) begin
            vecs++; errs++;
            $display("FAIL rnd_progress: completed %0d required 40", n_done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
